tsn_tx_select_cbs: RTL and testbench

Per-port egress transmission selection for the TSN switch, parametrised in queue count. It combines per-queue gate states from the scheduled-traffic list executor with a per-queue choice of algorithm: strict priority, or a real 802.1Q credit-based shaper with signed credit counters. The highest-index eligible queue is granted whole frames onto a single AXI-Stream output. It sits between the per-queue output FIFOs and the MAC TX path.

---
 rtl/tsn_ts_pkg.sv | 30 +++
 rtl/tsn_cbs_credit.sv | 51 +++++
 rtl/tsn_tx_select_cbs.sv | 126 ++++++++++++
 tb/tb_tsn_tx_select_cbs.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsn_ts_pkg.sv
// rtl/tsn_ts_pkg.sv - shared states, defaults and saturating credit arithmetic for tx selection
package tsn_ts_pkg;

  localparam logic TS_IDLE     = 1'b0;
  localparam logic TS_TRANSMIT = 1'b1;

  localparam int TS_CREDIT_WIDTH = 32;

  // Operands arrive widened to 64 bits so the raw sum cannot wrap before clamping to w bits.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int w);
    return sat_clamp(a + b, w);
  endfunction

  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int w);
    return sat_clamp(a - b, w);
  endfunction

endpackage

// File: rtl/tsn_cbs_credit.sv
// rtl/tsn_cbs_credit.sv - per-queue credit-based shaper credit counter with saturation
module tsn_cbs_credit import tsn_ts_pkg::*; #(
  parameter int CREDIT_WIDTH = TS_CREDIT_WIDTH
) (
  input  logic                    axis_aclk,
  input  logic                    axis_reset,
  input  logic                    enable,
  input  logic                    gate,
  input  logic                    pending,
  input  logic                    granted,
  input  logic                    beat_accept,
  input  logic [CREDIT_WIDTH-1:0] idle_slope,
  input  logic [CREDIT_WIDTH-1:0] send_slope,
  output logic [CREDIT_WIDTH-1:0] credit
);

  logic signed [63:0] cur;
  logic signed [63:0] idl;
  logic signed [63:0] snd;
  logic signed [63:0] sum_add;
  logic signed [63:0] sum_sub;
  logic [CREDIT_WIDTH-1:0] credit_nxt;

  always_comb begin
    cur = {{(64-CREDIT_WIDTH){credit[CREDIT_WIDTH-1]}}, credit};
    idl = {{(64-CREDIT_WIDTH){1'b0}}, idle_slope};
    snd = {{(64-CREDIT_WIDTH){1'b0}}, send_slope};
    sum_add = sat_add(cur, idl, CREDIT_WIDTH);
    sum_sub = sat_sub(cur, snd, CREDIT_WIDTH);
    credit_nxt = credit;
    if (!enable) begin
      credit_nxt = '0;
    end else if (granted) begin
      // The owning queue only pays per beat; a stalled or winning cycle holds.
      if (beat_accept) credit_nxt = sum_sub[CREDIT_WIDTH-1:0];
    end else if (gate) begin
      if (pending)
        credit_nxt = sum_add[CREDIT_WIDTH-1:0];
      else if (cur < 0 && sum_add < 0)
        credit_nxt = sum_add[CREDIT_WIDTH-1:0];
      else
        credit_nxt = '0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) credit <= '0;
    else            credit <= credit_nxt;
  end

endmodule

// File: rtl/tsn_tx_select_cbs.sv
// rtl/tsn_tx_select_cbs.sv - per-port egress selection: gates, strict priority / CBS, whole-frame grant
module tsn_tx_select_cbs import tsn_ts_pkg::*; #(
  parameter int AXIS_DATA_WIDTH  = 256,
  parameter int AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES       = 8,
  parameter int CREDIT_WIDTH     = TS_CREDIT_WIDTH,
  parameter int QIDX_WIDTH       = 3
) (
  input  logic                                   axis_aclk,
  input  logic                                   axis_reset,
  input  logic [NUM_QUEUES*AXIS_DATA_WIDTH-1:0]  s_axis_q_tdata,
  input  logic [NUM_QUEUES*AXIS_DATA_WIDTH/8-1:0] s_axis_q_tkeep,
  input  logic [NUM_QUEUES*AXIS_TUSER_WIDTH-1:0] s_axis_q_tuser,
  input  logic [NUM_QUEUES-1:0]                  s_axis_q_tvalid,
  input  logic [NUM_QUEUES-1:0]                  s_axis_q_tlast,
  output logic [NUM_QUEUES-1:0]                  s_axis_q_tready,
  output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                  gate_states,
  input  logic [NUM_QUEUES-1:0]                  cbs_enable,
  input  logic [NUM_QUEUES*CREDIT_WIDTH-1:0]     idle_slope,
  input  logic [NUM_QUEUES*CREDIT_WIDTH-1:0]     send_slope,
  output logic [NUM_QUEUES*CREDIT_WIDTH-1:0]     credit_out,
  output logic [QIDX_WIDTH-1:0]                  active_queue,
  output logic                                   busy
);

  localparam int KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  logic                  state;
  logic                  state_nxt;
  logic [QIDX_WIDTH-1:0] grant;
  logic [QIDX_WIDTH-1:0] sel;
  logic [NUM_QUEUES-1:0] elig;
  logic [NUM_QUEUES-1:0] granted_q;
  logic [NUM_QUEUES-1:0] accept_q;
  logic                  start;

  // Ascending scan so the highest-index eligible queue wins.
  always_comb begin
    elig = '0;
    sel  = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      elig[q] = s_axis_q_tvalid[q] & gate_states[q] &
                (cbs_enable[q] ? ~credit_out[q*CREDIT_WIDTH + CREDIT_WIDTH - 1] : 1'b1);
      if (elig[q]) sel = QIDX_WIDTH'(q);
    end
  end

  assign start = (state == TS_IDLE) && (|elig) && m_axis_tready;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state <= TS_IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      if (start) grant <= sel;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == TS_IDLE) begin
      if (start) state_nxt = TS_TRANSMIT;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      state_nxt = TS_IDLE;
    end
  end

  always_comb begin
    m_axis_tdata    = '0;
    m_axis_tkeep    = '0;
    m_axis_tuser    = '0;
    m_axis_tvalid   = 1'b0;
    m_axis_tlast    = 1'b0;
    s_axis_q_tready = '0;
    if (state == TS_TRANSMIT) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (grant == QIDX_WIDTH'(q)) begin
          m_axis_tdata       = s_axis_q_tdata[q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
          m_axis_tkeep       = s_axis_q_tkeep[q*KEEP_WIDTH +: KEEP_WIDTH];
          m_axis_tuser       = s_axis_q_tuser[q*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
          m_axis_tvalid      = s_axis_q_tvalid[q];
          m_axis_tlast       = s_axis_q_tlast[q];
          s_axis_q_tready[q] = m_axis_tready;
        end
      end
    end
  end

  // The winning queue counts as granted in its selection cycle too, so it does not accrue then.
  always_comb begin
    granted_q = '0;
    accept_q  = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      granted_q[q] = ((state == TS_TRANSMIT) && (grant == QIDX_WIDTH'(q))) ||
                     (start && (sel == QIDX_WIDTH'(q)));
      accept_q[q]  = (state == TS_TRANSMIT) && (grant == QIDX_WIDTH'(q)) &&
                     s_axis_q_tvalid[q] && m_axis_tready;
    end
  end

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_credit
    tsn_cbs_credit #(.CREDIT_WIDTH(CREDIT_WIDTH)) u_credit (
      .axis_aclk   (axis_aclk),
      .axis_reset  (axis_reset),
      .enable      (cbs_enable[g]),
      .gate        (gate_states[g]),
      .pending     (s_axis_q_tvalid[g]),
      .granted     (granted_q[g]),
      .beat_accept (accept_q[g]),
      .idle_slope  (idle_slope[g*CREDIT_WIDTH +: CREDIT_WIDTH]),
      .send_slope  (send_slope[g*CREDIT_WIDTH +: CREDIT_WIDTH]),
      .credit      (credit_out[g*CREDIT_WIDTH +: CREDIT_WIDTH])
    );
  end

  assign active_queue = grant;
  assign busy         = (state == TS_TRANSMIT);

endmodule

// File: tb/tb_tsn_tx_select_cbs.sv
// tb/tb_tsn_tx_select_cbs.sv - directed self-checking bench for tsn_tx_select_cbs
module tb_tsn_tx_select_cbs;

  localparam int DW = 32;
  localparam int UW = 8;
  localparam int NQ = 8;
  localparam int CW = 32;
  localparam int QW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NQ*DW-1:0]   s_tdata;
  logic [NQ*DW/8-1:0] s_tkeep;
  logic [NQ*UW-1:0]   s_tuser;
  logic [NQ-1:0]      s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]      m_tdata;
  logic [DW/8-1:0]    m_tkeep;
  logic [UW-1:0]      m_tuser;
  logic               m_tvalid, m_tlast, m_tready;
  logic [NQ-1:0]      gate, cbs_en;
  logic [NQ*CW-1:0]   idle_sl, send_sl, credit;
  logic [QW-1:0]      aq;
  logic               busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Source FIFO model: each queue presents loaded-but-unsent frames of flen beats.
  int loaded[NQ];
  int done_f[NQ];
  int beat[NQ];
  int flen[NQ];
  logic [NQ-1:0] stall;
  logic model_clear;

  int cyc = 0;
  int log_q[$];
  int log_b[$];
  int log_c[$];

  tsn_tx_select_cbs #(
    .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .NUM_QUEUES(NQ),
    .CREDIT_WIDTH(CW), .QIDX_WIDTH(QW)
  ) dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_q_tdata(s_tdata), .s_axis_q_tkeep(s_tkeep), .s_axis_q_tuser(s_tuser),
    .s_axis_q_tvalid(s_tvalid), .s_axis_q_tlast(s_tlast), .s_axis_q_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .gate_states(gate), .cbs_enable(cbs_en), .idle_slope(idle_sl), .send_slope(send_sl),
    .credit_out(credit), .active_queue(aq), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      s_tvalid[q] = (loaded[q] > done_f[q]) && !stall[q];
      s_tlast[q]  = (beat[q] == flen[q] - 1);
      s_tdata[q*DW +: DW]  = {16'(q), 16'(beat[q])};
      s_tkeep[q*4 +: 4]    = 4'hF;
      s_tuser[q*UW +: UW]  = 8'(q);
    end
  end

  always @(posedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (model_clear) begin
        beat[q]   <= 0;
        done_f[q] <= loaded[q];
      end else if (s_tvalid[q] && s_tready[q]) begin
        if (beat[q] == flen[q] - 1) begin
          beat[q]   <= 0;
          done_f[q] <= done_f[q] + 1;
        end else begin
          beat[q] <= beat[q] + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_tvalid && m_tready) begin
      log_q.push_back(int'(m_tdata[31:16]));
      log_b.push_back(int'(m_tdata[15:0]));
      log_c.push_back(cyc);
    end
  end

  function automatic int cr(input int q);
    logic signed [CW-1:0] v;
    v = credit[q*CW +: CW];
    return int'(v);
  endfunction

  task automatic wait_log(input int n, input int budget);
    int w;
    w = 0;
    while (log_q.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; model_clear = 1'b1;
    gate = '1; cbs_en = '0; idle_sl = '0; send_sl = '0; m_tready = 1'b1; stall = '0;
    repeat (2) @(negedge clk);
    model_clear = 1'b0;
    flen[3] = 2; loaded[3] = loaded[3] + 1;
    @(negedge clk); #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
    n_cmp++; if (s_tready !== 8'h00) begin n_fail++; $display("FAIL reset_tready: got %h expected 00", s_tready); end
    n_cmp++; if (busy !== 1'b0 || aq !== 3'd0) begin n_fail++; $display("FAIL reset_busy_aq: got busy=%b aq=%0d expected 0/0", busy, aq); end
    n_cmp++; if (credit !== '0) begin n_fail++; $display("FAIL reset_credit: got %h expected 0", credit); end
    model_clear = 1'b1;
    @(negedge clk);
    model_clear = 1'b0; rst = 1'b0;
  endtask

  task automatic test_strict_priority();
    int base, k, eq, eb, ec;
    flen[2] = 3; flen[5] = 3;
    base = log_q.size();
    @(negedge clk);
    loaded[2] = loaded[2] + 1; loaded[5] = loaded[5] + 1;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL strict_latency: got tvalid=%b expected 0", m_tvalid); end
    @(negedge clk); #1;
    n_cmp++; if (aq !== 3'd5 || busy !== 1'b1 || m_tvalid !== 1'b1) begin n_fail++; $display("FAIL strict_grant: got aq=%0d busy=%b tvalid=%b expected 5/1/1", aq, busy, m_tvalid); end
    n_cmp++; if (s_tready !== 8'h20) begin n_fail++; $display("FAIL strict_tready: got %h expected 20", s_tready); end
    wait_log(base + 6, 40);
    n_cmp++;
    if (log_q.size() < base + 6) begin
      n_fail++; $display("FAIL strict_timeout: got %0d beats expected 6", log_q.size() - base);
    end else begin
      for (k = 0; k < 6; k++) begin
        eq = (k < 3) ? 5 : 2;
        eb = k % 3;
        ec = (k < 3) ? k : k + 1;
        n_cmp++;
        if (log_q[base+k] !== eq || log_b[base+k] !== eb || log_c[base+k] - log_c[base] !== ec) begin
          n_fail++;
          $display("FAIL strict_beat%0d: got q=%0d b=%0d t=%0d expected q=%0d b=%0d t=%0d", k,
                   log_q[base+k], log_b[base+k], log_c[base+k] - log_c[base], eq, eb, ec);
        end
      end
    end
  endtask

  task automatic test_gate();
    int base, k, eq, eb, ec;
    gate = 8'h7F; flen[7] = 3; flen[1] = 4;
    base = log_q.size();
    @(negedge clk);
    loaded[1] = loaded[1] + 1; loaded[7] = loaded[7] + 1;
    @(negedge clk); #1;
    n_cmp++; if (aq !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL gate_closed_grant: got aq=%0d busy=%b expected 1/1", aq, busy); end
    @(negedge clk);
    gate = 8'hFF;
    #1;
    n_cmp++; if (aq !== 3'd1 || m_tvalid !== 1'b1) begin n_fail++; $display("FAIL gate_open_midframe: got aq=%0d tvalid=%b expected 1/1", aq, m_tvalid); end
    wait_log(base + 7, 40);
    n_cmp++;
    if (log_q.size() < base + 7) begin
      n_fail++; $display("FAIL gate_timeout: got %0d beats expected 7", log_q.size() - base);
    end else begin
      for (k = 0; k < 7; k++) begin
        eq = (k < 4) ? 1 : 7;
        eb = (k < 4) ? k : k - 4;
        ec = (k < 4) ? k : k + 1;
        n_cmp++;
        if (log_q[base+k] !== eq || log_b[base+k] !== eb || log_c[base+k] - log_c[base] !== ec) begin
          n_fail++;
          $display("FAIL gate_beat%0d: got q=%0d b=%0d t=%0d expected q=%0d b=%0d t=%0d", k,
                   log_q[base+k], log_b[base+k], log_c[base+k] - log_c[base], eq, eb, ec);
        end
      end
    end
  endtask

  task automatic test_cbs_shaping();
    int base, t, k, eq, eb, ec;
    flen[6] = 4; flen[3] = 5;
    base = log_q.size();
    @(negedge clk);
    cbs_en[6] = 1'b1; idle_sl[6*CW +: CW] = 32'd10; send_sl[6*CW +: CW] = 32'd40;
    loaded[6] = loaded[6] + 2; loaded[3] = loaded[3] + 1;
    wait_log(base + 4, 40);
    n_cmp++; if (cr(6) !== -160) begin n_fail++; $display("FAIL cbs_after_frame: got %0d expected -160", cr(6)); end
    n_cmp++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cbs_idle_gap: got tvalid=%b busy=%b expected 0/0", m_tvalid, busy); end
    @(negedge clk); #1;
    n_cmp++; if (aq !== 3'd3 || cr(6) !== -150) begin n_fail++; $display("FAIL cbs_strict_wins: got aq=%0d credit=%0d expected 3/-150", aq, cr(6)); end
    wait_log(base + 13, 80);
    n_cmp++;
    if (log_q.size() < base + 13) begin
      n_fail++; $display("FAIL cbs_timeout: got %0d beats expected 13", log_q.size() - base);
    end else begin
      t = log_c[base+3];
      for (k = 4; k < 13; k++) begin
        eq = (k < 9) ? 3 : 6;
        eb = (k < 9) ? k - 4 : k - 9;
        ec = (k < 9) ? k - 2 : k + 9;
        n_cmp++;
        if (log_q[base+k] !== eq || log_b[base+k] !== eb || log_c[base+k] - t !== ec) begin
          n_fail++;
          $display("FAIL cbs_beat%0d: got q=%0d b=%0d t=%0d expected q=%0d b=%0d t=%0d", k,
                   log_q[base+k], log_b[base+k], log_c[base+k] - t, eq, eb, ec);
        end
      end
    end
    @(negedge clk);
    cbs_en[6] = 1'b0;
  endtask

  task automatic test_idle_credit();
    @(negedge clk);
    m_tready = 1'b0; cbs_en[4] = 1'b1;
    idle_sl[4*CW +: CW] = 32'd10; send_sl[4*CW +: CW] = 32'd0;
    flen[4] = 1; loaded[4] = loaded[4] + 1;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (cr(4) !== 50 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_accrue: got credit=%0d busy=%b expected 50/0", cr(4), busy); end
    stall[4] = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (cr(4) !== 0) begin n_fail++; $display("FAIL empty_clear_pos: got %0d expected 0", cr(4)); end
    stall[4] = 1'b0; m_tready = 1'b1;
    idle_sl[4*CW +: CW] = 32'd20; send_sl[4*CW +: CW] = 32'd30;
    @(negedge clk); #1;
    n_cmp++; if (aq !== 3'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL idle_grant: got aq=%0d busy=%b expected 4/1", aq, busy); end
    @(negedge clk); #1;
    n_cmp++; if (cr(4) !== -30) begin n_fail++; $display("FAIL neg_debit: got %0d expected -30", cr(4)); end
    @(negedge clk); #1;
    n_cmp++; if (cr(4) !== -10) begin n_fail++; $display("FAIL neg_recover: got %0d expected -10", cr(4)); end
    @(negedge clk); #1;
    n_cmp++; if (cr(4) !== 0) begin n_fail++; $display("FAIL neg_clamp: got %0d expected 0", cr(4)); end
    cbs_en[4] = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    m_tready = 1'b0; cbs_en[0] = 1'b1; idle_sl[0*CW +: CW] = 32'h4000_0000;
    flen[0] = 2; loaded[0] = loaded[0] + 1;
    @(negedge clk); #1;
    n_cmp++; if (credit[0 +: CW] !== 32'h4000_0000) begin n_fail++; $display("FAIL sat_first: got %h expected 40000000", credit[0 +: CW]); end
    @(negedge clk); #1;
    n_cmp++; if (credit[0 +: CW] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_clamp: got %h expected 7fffffff", credit[0 +: CW]); end
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (credit[0 +: CW] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected 7fffffff", credit[0 +: CW]); end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    rst = 1'b1; model_clear = 1'b1; cbs_en = '0; m_tready = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_clear = 1'b0;
    cbs_en[2] = 1'b1; idle_sl[2*CW +: CW] = 32'd0; send_sl[2*CW +: CW] = 32'd5;
    flen[2] = 4; loaded[2] = loaded[2] + 1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (cr(2) !== -10 || m_tvalid !== 1'b1 || m_tdata[15:0] !== 16'd2) begin
      n_fail++; $display("FAIL midframe_pre: got credit=%0d tvalid=%b beat=%0d expected -10/1/2", cr(2), m_tvalid, m_tdata[15:0]);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (m_tvalid !== 1'b0 || s_tready !== 8'h00) begin n_fail++; $display("FAIL midframe_out: got tvalid=%b tready=%h expected 0/00", m_tvalid, s_tready); end
    n_cmp++; if (credit !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL midframe_state: got credit=%h busy=%b expected 0/0", credit, busy); end
    model_clear = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_clear = 1'b0;
  endtask

  initial begin
    for (int q = 0; q < NQ; q++) begin
      loaded[q] = 0; flen[q] = 1;
    end
    stall = '0; model_clear = 1'b1; rst = 1'b1; m_tready = 1'b1;
    gate = '1; cbs_en = '0; idle_sl = '0; send_sl = '0;
    test_reset();
    test_strict_priority();
    test_gate();
    test_cbs_shaping();
    test_idle_credit();
    test_saturation();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
